// File: rtl/voice_frame_sched_pkg.sv
// voice_frame_sched_pkg: shared FSM encodings, mode struct and sizing helpers for the voice frame scheduler
package voice_frame_sched_pkg;
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] FIR_WAIT   = 2'd1;
  localparam logic [1:0] SHIFT_WAIT = 2'd2;
  typedef struct packed {
    logic play_sel;
    logic sel_fir;
  } mode_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int gain_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/voice_frame_sched_if.sv
// voice_frame_sched_if: codec/datapath handshake bundle between the scheduler and its environment
interface voice_frame_sched_if #(parameter int GAIN_W = 4);
  logic              new_frame;
  logic              change_en;
  logic              rising_tone;
  logic              fir_done;
  logic              shift_done;
  logic              clr_ovr;
  logic              fir_start;
  logic              shift_start;
  logic              frame_done;
  logic              sel_fir;
  logic              play_sel;
  logic [GAIN_W-1:0] gain;
  logic              overrun;
  logic              busy;
  modport master (
    input  new_frame, change_en, rising_tone, fir_done, shift_done, clr_ovr,
    output fir_start, shift_start, frame_done, sel_fir, play_sel, gain, overrun, busy
  );
  modport slave (
    output new_frame, change_en, rising_tone, fir_done, shift_done, clr_ovr,
    input  fir_start, shift_start, frame_done, sel_fir, play_sel, gain, overrun, busy
  );
endinterface

// File: rtl/voice_frame_sched_debounce.sv
// voice_frame_sched_debounce: synchronises a raw switch and accepts a new level after DEB_CYCLES stable samples
module voice_frame_sched_debounce
  import voice_frame_sched_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], din};
    cnt_d  = (sync_q[1] == db_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    db_d   = (sync_q[1] != db_q && cnt_q == LAST) ? sync_q[1] : db_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end
  assign dout = db_q;
endmodule

// File: rtl/voice_frame_sched.sv
// voice_frame_sched: per-frame FIR/pitch-shift sequencer with debounced mode switches and click-free gain ramp
module voice_frame_sched
  import voice_frame_sched_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000,
  parameter int TIMEOUT    = 2000,
  parameter int GAIN_W     = 4
) (
  input logic                 clk,
  input logic                 reset,
  voice_frame_sched_if.master bus
);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);
  localparam logic [GAIN_W-1:0] GMAX  = GAIN_W'(gain_max(GAIN_W));
  logic [2:0]        nf_q, nf_d;
  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              fir_start_q, fir_start_d;
  logic              shift_start_q, shift_start_d;
  logic              frame_done_q, frame_done_d;
  logic              overrun_q, overrun_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  mode_t             mode_q, mode_d, mode_db;
  logic              frame_tick, timeout, pending, ce_db, rt_db;
  voice_frame_sched_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ce (
    .clk(clk), .reset(reset), .din(bus.change_en), .dout(ce_db)
  );
  voice_frame_sched_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rt (
    .clk(clk), .reset(reset), .din(bus.rising_tone), .dout(rt_db)
  );
  always_comb begin
    nf_d          = {nf_q[1:0], bus.new_frame};
    frame_tick    = nf_q[1] & ~nf_q[2];
    state_d       = state_q;
    fir_start_d   = 1'b0;
    shift_start_d = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      IDLE: if (frame_tick) begin
        state_d       = mode_q.sel_fir ? FIR_WAIT : SHIFT_WAIT;
        fir_start_d   = mode_q.sel_fir;
        shift_start_d = !mode_q.sel_fir;
      end
      FIR_WAIT: if (bus.fir_done) begin
        state_d       = SHIFT_WAIT;
        shift_start_d = 1'b1;
      end else if (cnt_q == TLAST) state_d = IDLE;
      SHIFT_WAIT: if (bus.shift_done) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end else if (cnt_q == TLAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // any return to IDLE without a frame_done is an abort
    timeout   = state_q != IDLE && state_d == IDLE && !frame_done_d;
    cnt_d     = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    overrun_d = (timeout || (frame_tick && state_q != IDLE)) ? 1'b1 : bus.clr_ovr ? 1'b0 : overrun_q;
    mode_db   = '{play_sel: ce_db, sel_fir: rt_db};
    pending   = mode_db != mode_q;
    mode_d    = (frame_done_q && pending && gain_q == '0) ? mode_db : mode_q;
    gain_d    = !frame_done_q ? gain_q :
                pending ? ((gain_q != '0) ? gain_q - 1'b1 : gain_q) :
                          ((gain_q != GMAX) ? gain_q + 1'b1 : gain_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      nf_q          <= '0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      fir_start_q   <= 1'b0;
      shift_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      gain_q        <= GMAX;
      mode_q        <= '0;
    end else begin
      nf_q          <= nf_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fir_start_q   <= fir_start_d;
      shift_start_q <= shift_start_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      gain_q        <= gain_d;
      mode_q        <= mode_d;
    end
  end
  assign bus.fir_start   = fir_start_q;
  assign bus.shift_start = shift_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.sel_fir     = mode_q.sel_fir;
  assign bus.play_sel    = mode_q.play_sel;
  assign bus.gain        = gain_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = state_q != IDLE;
endmodule
